// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Owner encoding steers read data in the cycle after a granted read.
package dmem_arbiter_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating count of cycles the external port lost arbitration.
// Present only when DMEM_ARB_STARVE_EN is defined.
module dmem_starve_cnt #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ext_req,
  input  logic ext_gnt,
  output logic force_ext
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] MAX = CW'(LIMIT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (ext_gnt) begin
      cnt_q <= '0;
    end else if (ext_req && (cnt_q != MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign force_ext = ext_req && (cnt_q == MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// CPU / external-port arbiter for a single-port data memory.
// Define DMEM_ARB_STARVE_EN to bound external-port starvation.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_re,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  logic          cpu_act;
  logic          cpu_gnt;
  logic          ext_go;
  logic          force_ext;
  logic          cpu_rd;
  logic          rd_q;
  owner_e        own_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] ext_rdata_q;

  assign cpu_act   = cpu_re | cpu_we;
  assign cpu_gnt   = !rst && cpu_act && !force_ext;
  assign ext_go    = !rst && ext_req && !cpu_gnt;
  assign ext_gnt   = ext_go;
  assign cpu_stall = !rst && cpu_act && !cpu_gnt;

`ifdef DMEM_ARB_STARVE_EN
  dmem_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .ext_req   (ext_req),
    .ext_gnt   (ext_go),
    .force_ext (force_ext)
  );
`else
  assign force_ext = 1'b0;
`endif

  // A simultaneous load+store from the CPU is a store only.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    unique case (1'b1)
      cpu_gnt: begin
        mem_we    = cpu_we;
        mem_re    = !cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      ext_go: begin
        mem_we    = ext_we;
        mem_re    = !ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_rd     = !rst && rd_q && (own_q == OWN_CPU);
  assign ext_rvalid = !rst && rd_q && (own_q == OWN_EXT);

  assign cpu_rdata = rst    ? '0 :
                     cpu_rd ? mem_rdata : cpu_rdata_q;
  assign ext_rdata = rst        ? '0 :
                     ext_rvalid ? mem_rdata : ext_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q        <= 1'b0;
      own_q       <= OWN_CPU;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      rd_q  <= mem_re;
      own_q <= ext_go ? OWN_EXT : OWN_CPU;
      if (cpu_gnt || ext_go) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      if (cpu_rd) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (ext_rvalid) begin
        ext_rdata_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous memory model.
// Starvation expectations follow DMEM_ARB_STARVE_EN.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_re;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [15:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [15:0] ext_rdata;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(
    .AW           (16),
    .DW           (16),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_re     (cpu_re),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle;
    cpu_re  = 1'b0;
    cpu_we  = 1'b0;
    ext_req = 1'b0;
    ext_we  = 1'b0;
  endtask

  initial begin
    logic exp_g;
    logic exp_v;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h40] = 16'hBEEF;
    mem[8'h10] = 16'h1234;
    mem_rdata  = 16'h0;

    // reset with both requesters active
    rst       = 1'b1;
    cpu_re    = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0040;
    cpu_wdata = 16'h0;
    ext_req   = 1'b1;
    ext_we    = 1'b0;
    ext_addr  = 16'h0010;
    ext_wdata = 16'h0;
    tick();
    tick();
    chk("rst_ext_gnt", ext_gnt, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rvalid", ext_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_ext_rdata", ext_rdata, 0);
    rst = 1'b0;
    idle();
    tick();

    // CPU load alone
    cpu_re   = 1'b1;
    cpu_addr = 16'h0040;
    #1;
    chk("ld_mem_re", mem_re, 1);
    chk("ld_mem_addr", mem_addr, 16'h0040);
    chk("ld_stall", cpu_stall, 0);
    tick();
    idle();
    #1;
    chk("ld_rdata", cpu_rdata, 16'hBEEF);
    chk("ld_no_rvalid", ext_rvalid, 0);
    tick();
    chk("idle_mem_re", mem_re, 0);
    chk("idle_addr_hold", mem_addr, 16'h0040);

    // external read alone
    ext_req  = 1'b1;
    ext_we   = 1'b0;
    ext_addr = 16'h0010;
    #1;
    chk("er_gnt", ext_gnt, 1);
    chk("er_mem_re", mem_re, 1);
    chk("er_addr", mem_addr, 16'h0010);
    tick();
    idle();
    #1;
    chk("er_rvalid", ext_rvalid, 1);
    chk("er_rdata", ext_rdata, 16'h1234);
    chk("er_cpu_hold", cpu_rdata, 16'hBEEF);
    tick();
    chk("er_pulse", ext_rvalid, 0);

    // CPU store collides with external write
    cpu_we    = 1'b1;
    cpu_addr  = 16'h0020;
    cpu_wdata = 16'hAAAA;
    ext_req   = 1'b1;
    ext_we    = 1'b1;
    ext_addr  = 16'h0021;
    ext_wdata = 16'h5555;
    #1;
    chk("col_ext_gnt", ext_gnt, 0);
    chk("col_mem_we", mem_we, 1);
    chk("col_addr", mem_addr, 16'h0020);
    chk("col_wdata", mem_wdata, 16'hAAAA);
    chk("col_stall", cpu_stall, 0);
    tick();
    cpu_we = 1'b0;
    #1;
    chk("ew_gnt", ext_gnt, 1);
    chk("ew_addr", mem_addr, 16'h0021);
    chk("ew_wdata", mem_wdata, 16'h5555);
    tick();
    idle();
    #1;
    chk("ew_no_rvalid", ext_rvalid, 0);
    chk("mem20", mem[8'h20], 16'hAAAA);
    chk("mem21", mem[8'h21], 16'h5555);

    // load and store together is a store
    cpu_re    = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h0022;
    cpu_wdata = 16'h7777;
    #1;
    chk("rw_mem_re", mem_re, 0);
    chk("rw_mem_we", mem_we, 1);
    tick();
    idle();
    #1;
    chk("rw_mem22", mem[8'h22], 16'h7777);
    chk("rw_cpu_hold", cpu_rdata, 16'hBEEF);
    tick();

    // continuous CPU loads against a held external read
    cpu_re   = 1'b1;
    cpu_addr = 16'h0040;
    ext_req  = 1'b1;
    ext_we   = 1'b0;
    ext_addr = 16'h0010;
    for (int k = 0; k < 20; k++) begin
`ifdef DMEM_ARB_STARVE_EN
      exp_g = ((k % 5) == 4);
      exp_v = (k > 0) && ((k % 5) == 0);
`else
      exp_g = 1'b0;
      exp_v = 1'b0;
`endif
      #1;
      chk($sformatf("sv_gnt%0d", k), ext_gnt, exp_g);
      chk($sformatf("sv_stall%0d", k), cpu_stall, exp_g);
      chk($sformatf("sv_rvalid%0d", k), ext_rvalid, exp_v);
      if (k > 0) chk($sformatf("sv_crd%0d", k), cpu_rdata, 16'hBEEF);
      tick();
    end
    idle();
    tick();

    // reset lands the cycle after an external read grant
    ext_req  = 1'b1;
    ext_we   = 1'b0;
    ext_addr = 16'h0010;
    #1;
    chk("rr_gnt", ext_gnt, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("rr_rvalid", ext_rvalid, 0);
    chk("rr_ext_rdata", ext_rdata, 0);
    chk("rr_cpu_rdata", cpu_rdata, 0);
    chk("rr_ext_gnt", ext_gnt, 0);
    chk("rr_mem_re", mem_re, 0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("rr_post_rvalid", ext_rvalid, 0);
    chk("rr_post_crd", cpu_rdata, 0);
    chk("rr_post_erd", ext_rdata, 0);
    tick();
    chk("rr_late_rvalid", ext_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
